// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo
//   UART 8N1 transmitter fed by a small byte FIFO. A producer pushes bytes
//   with a valid/ready handshake; queued bytes are serialized LSB-first,
//   back-to-back with no idle gap between frames.
//
// Ports
//   i_Clk         system clock, rising edge
//   i_Rst         asynchronous active-high reset
//   i_TX_DV       producer byte valid
//   i_TX_Byte     producer byte, taken when i_TX_DV & o_TX_Ready
//   o_TX_Ready    FIFO not full
//   o_TX_Serial   UART line, idle high
//   o_TX_Active   high while a frame (start..stop) is on the line
//   o_TX_Done     one-cycle pulse on the last cycle of each stop bit
//   o_FIFO_Count  bytes waiting in the FIFO (byte in flight not counted)
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 104,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          i_Clk,
    input  logic                          i_Rst,
    input  logic                          i_TX_DV,
    input  logic [7:0]                    i_TX_Byte,
    output logic                          o_TX_Ready,
    output logic                          o_TX_Serial,
    output logic                          o_TX_Active,
    output logic                          o_TX_Done,
    output logic [$clog2(FIFO_DEPTH):0]   o_FIFO_Count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [AW:0]   CNT_FULL = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    // FIFO storage and bookkeeping
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          push, pop, fifo_empty;

    // Serializer state
    state_t        state, state_n;
    logic [CW-1:0] clk_cnt, clk_cnt_n;
    logic [2:0]    bit_idx, bit_idx_n;
    logic [7:0]    shift, shift_n;
    logic          bit_end;

    assign fifo_empty   = (count == '0);
    assign o_TX_Ready   = (count != CNT_FULL);
    assign push         = i_TX_DV & o_TX_Ready;
    assign bit_end      = (clk_cnt == CNT_LAST);
    assign o_FIFO_Count = count;

    // Storage has no reset: stale entries are unreachable once pointers clear.
    always_ff @(posedge i_Clk) begin
        if (push)
            mem[wr_ptr] <= i_TX_Byte;
    end

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            // Simultaneous push and pop leaves the count unchanged.
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            state   <= IDLE;
            clk_cnt <= '0;
            bit_idx <= '0;
            shift   <= '0;
        end else begin
            state   <= state_n;
            clk_cnt <= clk_cnt_n;
            bit_idx <= bit_idx_n;
            shift   <= shift_n;
        end
    end

    always_comb begin
        state_n     = state;
        clk_cnt_n   = bit_end ? '0 : clk_cnt + 1'b1;
        bit_idx_n   = bit_idx;
        shift_n     = shift;
        pop         = 1'b0;
        o_TX_Serial = 1'b1;
        o_TX_Done   = 1'b0;
        o_TX_Active = 1'b1;
        case (state)
            IDLE: begin
                o_TX_Active = 1'b0;
                clk_cnt_n   = '0;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_n = mem[rd_ptr];
                    state_n = START;
                end
            end
            START: begin
                o_TX_Serial = 1'b0;
                if (bit_end) begin
                    bit_idx_n = '0;
                    state_n   = DATA;
                end
            end
            DATA: begin
                o_TX_Serial = shift[bit_idx];
                if (bit_end) begin
                    if (bit_idx == 3'd7)
                        state_n = STOP;
                    else
                        bit_idx_n = bit_idx + 3'd1;
                end
            end
            STOP: begin
                o_TX_Done = bit_end;
                if (bit_end) begin
                    // Chain straight into the next start bit when data is waiting.
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        shift_n = mem[rd_ptr];
                        state_n = START;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo
//   Directed bench for uart_tx_fifo with CLKS_PER_BIT=4, FIFO_DEPTH=4.
//   A line decoder runs alongside the stimulus and collects received bytes.
module tb_uart_tx_fifo;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tx_dv = 1'b0;
    logic [7:0] tx_byte = 8'h00;
    logic       tx_ready, tx_serial, tx_active, tx_done;
    logic [2:0] fifo_count;

    int   n_assert = 0;
    int   n_fail   = 0;
    logic mon_en   = 1'b1;
    logic [7:0] rxq[$];

    uart_tx_fifo #(.CLKS_PER_BIT(4), .FIFO_DEPTH(4)) dut (
        .i_Clk        (clk),
        .i_Rst        (rst),
        .i_TX_DV      (tx_dv),
        .i_TX_Byte    (tx_byte),
        .o_TX_Ready   (tx_ready),
        .o_TX_Serial  (tx_serial),
        .o_TX_Active  (tx_active),
        .o_TX_Done    (tx_done),
        .o_FIFO_Count (fifo_count)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Cycle-exact check of a frame sequence; entered on the first start-bit cycle.
    task automatic watch(input logic [19:0] bits, input int nbits);
        for (int c = 0; c < nbits * 4; c++) begin
            chk($sformatf("line_c%0d", c), {31'd0, tx_serial}, {31'd0, bits[c / 4]});
            chk($sformatf("active_c%0d", c), {31'd0, tx_active}, 32'd1);
            chk($sformatf("done_c%0d", c), {31'd0, tx_done}, {31'd0, (c % 40) == 39});
            tick();
        end
    endtask

    // Line decoder: detects a start bit, samples mid-bit, queues the byte.
    initial begin
        logic       en;
        logic [7:0] d;
        logic       st;
        forever begin
            tick();
            if (!rst && tx_serial === 1'b0) begin
                en = mon_en;
                d  = 8'h00;
                repeat (2) tick();
                if (en) chk("mon_start", {31'd0, tx_serial}, 32'd0);
                for (int i = 0; i < 8; i++) begin
                    repeat (4) tick();
                    d[i] = tx_serial;
                end
                repeat (4) tick();
                st = tx_serial;
                if (en) begin
                    chk("mon_stop", {31'd0, st}, 32'd1);
                    rxq.push_back(d);
                end
                tick();
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] b [8];
        logic [7:0] got;
        b = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};

        // Reset state, then idle
        tick();
        chk("rst_serial", {31'd0, tx_serial}, 32'd1);
        chk("rst_ready",  {31'd0, tx_ready},  32'd1);
        chk("rst_active", {31'd0, tx_active}, 32'd0);
        chk("rst_done",   {31'd0, tx_done},   32'd0);
        chk("rst_count",  {29'd0, fifo_count}, 32'd0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("idle_serial", {31'd0, tx_serial}, 32'd1);
            chk("idle_ready",  {31'd0, tx_ready},  32'd1);
            chk("idle_count",  {29'd0, fifo_count}, 32'd0);
            chk("idle_active", {31'd0, tx_active}, 32'd0);
        end

        // Single byte 0xA5
        tx_dv = 1'b1; tx_byte = 8'hA5;
        tick();
        tx_dv = 1'b0;
        chk("a5_count_after_push", {29'd0, fifo_count}, 32'd1);
        chk("a5_line_before_start", {31'd0, tx_serial}, 32'd1);
        tick();
        watch({10'd0, 1'b1, 8'hA5, 1'b0}, 10);
        chk("a5_active_end", {31'd0, tx_active}, 32'd0);
        chk("a5_line_end",   {31'd0, tx_serial}, 32'd1);
        chk("a5_count_end",  {29'd0, fifo_count}, 32'd0);

        // 0x00 then 0xFF on consecutive cycles, streamed with no gap
        tx_dv = 1'b1; tx_byte = 8'h00;
        tick();
        tx_byte = 8'hFF;
        tick();
        tx_dv = 1'b0;
        chk("pushpop_same_edge_count", {29'd0, fifo_count}, 32'd1);
        watch({1'b1, 8'hFF, 1'b0, 1'b1, 8'h00, 1'b0}, 20);
        chk("stream_active_end", {31'd0, tx_active}, 32'd0);
        tick();

        // Fill the FIFO with i_TX_DV held; pop at stop end frees a slot
        rxq.delete();
        tx_dv = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("fill_ready_%0d", i), {31'd0, tx_ready}, 32'd1);
            tx_byte = b[i];
            tick();
        end
        chk("full_ready", {31'd0, tx_ready}, 32'd0);
        chk("full_count", {29'd0, fifo_count}, 32'd4);
        for (int k = 0; k < 36; k++) begin
            tx_byte = k[0] ? b[7] : b[6];
            tick();
            chk("full_hold_count", {29'd0, fifo_count}, 32'd4);
        end
        chk("full_stop_done", {31'd0, tx_done}, 32'd1);
        chk("full_stop_ready", {31'd0, tx_ready}, 32'd0);
        tx_byte = b[5];
        tick();
        chk("pop_edge_count", {29'd0, fifo_count}, 32'd3);
        chk("pop_edge_ready", {31'd0, tx_ready}, 32'd1);
        tick();
        chk("refill_count", {29'd0, fifo_count}, 32'd4);
        tx_dv = 1'b0;
        repeat (210) tick();
        chk("fill_rx_size", rxq.size(), 32'd6);
        for (int i = 0; i < 6; i++) begin
            got = (i < rxq.size()) ? rxq[i] : 8'hxx;
            chk($sformatf("fill_rx_byte_%0d", i), {24'd0, got}, {24'd0, b[i]});
        end
        chk("fill_count_end",  {29'd0, fifo_count}, 32'd0);
        chk("fill_active_end", {31'd0, tx_active}, 32'd0);

        // Reset during DATA bit 3 discards the frame and the queue
        mon_en = 1'b0;
        tx_dv = 1'b1; tx_byte = 8'h34;
        tick();
        tx_byte = 8'h5A;
        tick();
        tx_dv = 1'b0;
        repeat (17) tick();
        chk("bit3_line",  {31'd0, tx_serial}, 32'd0);
        chk("bit3_count", {29'd0, fifo_count}, 32'd1);
        rst = 1'b1;
        #1;
        chk("midrst_line",   {31'd0, tx_serial}, 32'd1);
        chk("midrst_active", {31'd0, tx_active}, 32'd0);
        chk("midrst_count",  {29'd0, fifo_count}, 32'd0);
        chk("midrst_ready",  {31'd0, tx_ready},  32'd1);
        tick();
        rst = 1'b0;
        repeat (50) tick();
        chk("postrst_line",   {31'd0, tx_serial}, 32'd1);
        chk("postrst_active", {31'd0, tx_active}, 32'd0);
        rxq.delete();
        mon_en = 1'b1;
        tx_dv = 1'b1; tx_byte = 8'hC3;
        tick();
        tx_dv = 1'b0;
        repeat (45) tick();
        chk("postrst_rx_size", rxq.size(), 32'd1);
        got = (rxq.size() > 0) ? rxq[0] : 8'hxx;
        chk("postrst_rx_byte", {24'd0, got}, 32'h0000_00C3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
